// File: rtl/segre_pkg.sv
// Shared types and constants for the data-cache memory-side responder (segre_dmmu).
package segre_pkg;

  localparam int unsigned DMMU_ADDR_SIZE     = 32;
  localparam int unsigned DMMU_LANE_SIZE     = 128;
  localparam int unsigned DMMU_INDEX_SIZE    = 2;
  localparam int unsigned DCACHE_NUM_LANES   = 2**DMMU_INDEX_SIZE;
  localparam int unsigned DCACHE_OFFSET_SIZE = $clog2(DMMU_LANE_SIZE/8);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB   = 3'd1,
    ST_RD   = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } dmmu_state_e;

  function automatic logic [DMMU_ADDR_SIZE-1:0] line_align(input logic [DMMU_ADDR_SIZE-1:0] addr);
    return {addr[DMMU_ADDR_SIZE-1:DCACHE_OFFSET_SIZE], {DCACHE_OFFSET_SIZE{1'b0}}};
  endfunction

endpackage

// File: rtl/segre_dmmu_lru.sv
// True-LRU age tracker for the data-cache lanes; victim is the lane holding the oldest age.
module segre_dmmu_lru
  import segre_pkg::*;
#(
  parameter int unsigned INDEX_SIZE = DMMU_INDEX_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fill,
  input  logic                  i_hit,
  input  logic [INDEX_SIZE-1:0] i_hit_lane,
  output logic [INDEX_SIZE-1:0] o_victim
);

  localparam int unsigned NUM_LANES = 2**INDEX_SIZE;

  typedef logic [NUM_LANES-1:0][INDEX_SIZE-1:0] ages_t;

  ages_t                 r_age;
  ages_t                 w_age_fill;
  ages_t                 w_age_next;
  logic [INDEX_SIZE-1:0] w_victim;

  // Touching a lane makes it youngest and ages every lane that was younger than it.
  function automatic ages_t touch(input ages_t a, input logic [INDEX_SIZE-1:0] l);
    ages_t res;
    res = a;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (INDEX_SIZE'(i) == l) begin
        res[i] = '0;
      end else if (a[i] < a[l]) begin
        res[i] = a[i] + 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    w_victim = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (r_age[i] == '1) begin
        w_victim = INDEX_SIZE'(i);
      end
    end
  end

  // A fill and a hit in the same cycle compose: fill first, then the hit.
  always_comb begin
    w_age_fill = i_fill ? touch(r_age, w_victim) : r_age;
    w_age_next = i_hit  ? touch(w_age_fill, i_hit_lane) : w_age_fill;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        r_age[i] <= INDEX_SIZE'(i);
      end
    end else begin
      r_age <= w_age_next;
    end
  end

  assign o_victim = w_victim;

endmodule

// File: rtl/segre_dmmu.sv
// Data-cache miss/writeback responder: victim writeback, line fill and LRU victim select.
// Optional one-entry writeback buffer enabled by defining SEGRE_DMMU_WB_BUFFER_EN.
module segre_dmmu
  import segre_pkg::*;
#(
  parameter int unsigned ADDR_SIZE         = DMMU_ADDR_SIZE,
  parameter int unsigned DCACHE_LANE_SIZE  = DMMU_LANE_SIZE,
  parameter int unsigned DCACHE_INDEX_SIZE = DMMU_INDEX_SIZE
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         dc_miss_i,
  input  logic [ADDR_SIZE-1:0]         dc_addr_i,
  input  logic                         dc_writeback_i,
  input  logic [ADDR_SIZE-1:0]         dc_wb_addr_i,
  input  logic [DCACHE_LANE_SIZE-1:0]  dc_data_i,
  input  logic                         dc_cache_access_i,
  input  logic [DCACHE_INDEX_SIZE-1:0] dc_hit_lane_i,
  output logic                         dc_data_rdy_o,
  output logic [ADDR_SIZE-1:0]         dc_addr_o,
  output logic [DCACHE_LANE_SIZE-1:0]  dc_data_o,
  output logic [DCACHE_INDEX_SIZE-1:0] dc_lru_index_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  output logic [DCACHE_LANE_SIZE-1:0]  mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [DCACHE_LANE_SIZE-1:0]  mem_rdata_i
);

  dmmu_state_e                 r_state;
  logic [ADDR_SIZE-1:0]        r_miss_addr;
  logic [ADDR_SIZE-1:0]        r_wb_addr;
  logic [DCACHE_LANE_SIZE-1:0] r_wb_data;
  logic [DCACHE_LANE_SIZE-1:0] r_fill_data;

  logic [ADDR_SIZE-1:0]        w_miss_line;
  logic [ADDR_SIZE-1:0]        w_victim_line;
  logic [ADDR_SIZE-1:0]        w_wb_addr;
  logic [DCACHE_LANE_SIZE-1:0] w_wb_data;
  logic                        w_in_wb;
  logic                        w_in_rd;

  assign w_miss_line   = line_align(dc_addr_i);
  assign w_victim_line = line_align(dc_wb_addr_i);
  assign w_in_wb       = (r_state == ST_WB);
  assign w_in_rd       = (r_state == ST_RD);

`ifdef SEGRE_DMMU_WB_BUFFER_EN
  logic                        r_buf_valid;
  logic [ADDR_SIZE-1:0]        r_buf_addr;
  logic [DCACHE_LANE_SIZE-1:0] r_buf_data;
  logic                        r_park;

  // WB always drains the buffer; r_wb_* only holds a victim waiting for the buffer to empty.
  assign w_wb_addr = r_buf_addr;
  assign w_wb_data = r_buf_data;
`else
  assign w_wb_addr = r_wb_addr;
  assign w_wb_data = r_wb_data;
`endif

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      r_state     <= ST_IDLE;
      r_miss_addr <= '0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_fill_data <= '0;
`ifdef SEGRE_DMMU_WB_BUFFER_EN
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_park      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
`ifdef SEGRE_DMMU_WB_BUFFER_EN
          if (dc_miss_i) begin
            r_miss_addr <= w_miss_line;
            if (dc_writeback_i && r_buf_valid) begin
              r_wb_addr <= w_victim_line;
              r_wb_data <= dc_data_i;
              r_park    <= 1'b1;
              r_state   <= ST_WB;
            end else if (dc_writeback_i) begin
              r_buf_addr  <= w_victim_line;
              r_buf_data  <= dc_data_i;
              r_buf_valid <= 1'b1;
              r_state     <= ST_RD;
            end else if (r_buf_valid && (r_buf_addr == w_miss_line)) begin
              r_fill_data <= r_buf_data;
              r_state     <= ST_RESP;
            end else begin
              r_state <= ST_RD;
            end
          end else if (r_buf_valid) begin
            r_state <= ST_WB;
          end
`else
          if (dc_miss_i) begin
            r_miss_addr <= w_miss_line;
            r_wb_addr   <= w_victim_line;
            r_wb_data   <= dc_data_i;
            r_state     <= dc_writeback_i ? ST_WB : ST_RD;
          end
`endif
        end
        ST_WB: begin
          if (mem_ack_i) begin
`ifdef SEGRE_DMMU_WB_BUFFER_EN
            if (r_park) begin
              r_buf_addr <= r_wb_addr;
              r_buf_data <= r_wb_data;
              r_park     <= 1'b0;
              r_state    <= ST_RD;
            end else begin
              r_buf_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
`else
            r_state <= ST_RD;
`endif
          end
        end
        ST_RD: begin
          if (mem_ack_i) begin
            r_fill_data <= mem_rdata_i;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_DONE;
        ST_DONE: begin
`ifdef SEGRE_DMMU_WB_BUFFER_EN
          r_state <= (r_buf_valid && !dc_miss_i) ? ST_WB : ST_IDLE;
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_o     = w_in_wb | w_in_rd;
  assign mem_we_o      = w_in_wb;
  assign mem_addr_o    = w_in_wb ? w_wb_addr : (w_in_rd ? r_miss_addr : '0);
  assign mem_wdata_o   = w_in_wb ? w_wb_data : '0;
  assign dc_data_rdy_o = (r_state == ST_RESP);
  assign dc_addr_o     = r_miss_addr;
  assign dc_data_o     = r_fill_data;

  segre_dmmu_lru #(
    .INDEX_SIZE (DCACHE_INDEX_SIZE)
  ) u_lru (
    .i_clk      (clk_i),
    .i_rst      (rsn_i),
    .i_fill     (dc_data_rdy_o),
    .i_hit      (dc_cache_access_i),
    .i_hit_lane (dc_hit_lane_i),
    .o_victim   (dc_lru_index_o)
  );

endmodule
